// File: rtl/fpnew_result_reorder.sv
// In-order completion buffer for FP opgroup results.
// Slot IDs go out as FPU tags; results commit strictly in issue order.
module fpnew_result_reorder #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4,
  localparam int unsigned IdWidth = $clog2(Depth)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  output logic [IdWidth-1:0] issue_id_o,
  input  logic               res_valid_i,
  output logic               res_ready_o,
  input  logic [IdWidth-1:0] res_id_i,
  input  logic [Width-1:0]   res_result_i,
  input  logic [4:0]         res_status_i,
  input  logic               res_ext_bit_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [Width-1:0]   out_result_o,
  output logic [4:0]         out_status_o,
  output logic               out_ext_bit_o,
  output logic               busy_o,
  output logic               error_o
);

  localparam logic [IdWidth:0] Full = (IdWidth+1)'(Depth);

  logic [Depth-1:0]   alloc_q, alloc_d;
  logic [Depth-1:0]   done_q, done_d;
  logic [Width-1:0]   result_q [Depth];
  logic [4:0]         status_q [Depth];
  logic [Depth-1:0]   ext_q;
  logic [IdWidth-1:0] head_q, tail_q;
  logic [IdWidth:0]   count_q;
  logic               error_q;

  logic issue_fire;
  logic commit;
  logic write_ok;
  logic write_fire;

  assign issue_ready_o = (count_q < Full);
  assign issue_id_o    = tail_q;
  assign res_ready_o   = 1'b1;
  assign out_valid_o   = done_q[head_q];
  assign out_result_o  = result_q[head_q];
  assign out_status_o  = status_q[head_q];
  assign out_ext_bit_o = ext_q[head_q];
  assign busy_o        = (count_q != '0);
  assign error_o       = error_q;

  assign issue_fire = issue_valid_i && issue_ready_o;
  assign commit     = out_valid_o && out_ready_i;
  assign write_ok   = alloc_q[res_id_i] && !done_q[res_id_i];
  assign write_fire = res_valid_i && write_ok;

  // A slot being issued this cycle is not yet allocated, so a
  // same-cycle result for it falls through write_ok as illegal.
  always_comb begin
    alloc_d = alloc_q;
    done_d  = done_q;
    if (commit) begin
      alloc_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
    end
    if (issue_fire) begin
      alloc_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
    end
    if (write_fire) begin
      done_d[res_id_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      alloc_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      alloc_q <= alloc_d;
      done_q  <= done_d;
      error_q <= res_valid_i && !write_ok;
      if (issue_fire) begin
        tail_q <= tail_q + 1'b1;
      end
      if (commit) begin
        head_q <= head_q + 1'b1;
      end
      unique case ({issue_fire, commit})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        result_q[i] <= '0;
        status_q[i] <= '0;
      end
      ext_q <= '0;
    end else if (!flush_i && write_fire) begin
      result_q[res_id_i] <= res_result_i;
      status_q[res_id_i] <= res_status_i;
      ext_q[res_id_i]    <= res_ext_bit_i;
    end
  end

endmodule

// File: tb/tb_fpnew_result_reorder.sv
// Directed bench for fpnew_result_reorder: vector table
// plus hand sequences for backpressure and pointer wrap.
module tb_fpnew_result_reorder;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        iv, ir;
  logic [1:0]  iid;
  logic        rv, rrdy;
  logic [1:0]  rid;
  logic [31:0] rres;
  logic [4:0]  rstat;
  logic        rext;
  logic        ov, ordy;
  logic [31:0] ores;
  logic [4:0]  ost;
  logic        oext;
  logic        busy, err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpnew_result_reorder #(.Width(32), .Depth(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .flush_i(flush),
    .issue_valid_i(iv),
    .issue_ready_o(ir),
    .issue_id_o(iid),
    .res_valid_i(rv),
    .res_ready_o(rrdy),
    .res_id_i(rid),
    .res_result_i(rres),
    .res_status_i(rstat),
    .res_ext_bit_i(rext),
    .out_valid_o(ov),
    .out_ready_i(ordy),
    .out_result_o(ores),
    .out_status_o(ost),
    .out_ext_bit_o(oext),
    .busy_o(busy),
    .error_o(err)
  );

  typedef struct {
    logic        rst, fl, iv, rv;
    logic [1:0]  rid;
    logic [31:0] rres;
    logic [4:0]  rs;
    logic        ordy;
    logic        e_ir;
    logic [1:0]  e_iid;
    logic        e_ov;
    logic [31:0] e_res;
    logic [4:0]  e_st;
    logic        e_busy, e_err;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t V(
    logic r, logic f, logic i, logic v,
    logic [1:0] id, logic [31:0] d, logic [4:0] s,
    logic o, logic eir, logic [1:0] eiid,
    logic eov, logic [31:0] eres, logic [4:0] est,
    logic eb, logic ee);
    vec_t x;
    x.rst = r; x.fl = f; x.iv = i; x.rv = v;
    x.rid = id; x.rres = d; x.rs = s; x.ordy = o;
    x.e_ir = eir; x.e_iid = eiid; x.e_ov = eov;
    x.e_res = eres; x.e_st = est;
    x.e_busy = eb; x.e_err = ee;
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic f, logic i, logic v,
                       logic [1:0] id, logic [31:0] d,
                       logic [4:0] s, logic o);
    rst = r; flush = f; iv = i; rv = v;
    rid = id; rres = d; rstat = s; rext = d[0]; ordy = o;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(logic o);
    drive(0, 0, 0, 0, 2'd0, 32'h0, 5'd0, o);
  endtask

  initial begin
    // in order
    tv.push_back(V(0,0,1,0,0,0,0,1, 1,1,0,0,0,1,0));
    tv.push_back(V(0,0,1,0,0,0,0,1, 1,2,0,0,0,1,0));
    tv.push_back(V(0,0,1,0,0,0,0,1, 1,3,0,0,0,1,0));
    tv.push_back(V(0,0,0,1,0,32'h3F800000,0,1,
                   1,3,1,32'h3F800000,0,1,0));
    tv.push_back(V(0,0,0,1,1,32'h40000000,1,1,
                   1,3,1,32'h40000000,1,1,0));
    tv.push_back(V(0,0,0,1,2,32'h40400000,2,1,
                   1,3,1,32'h40400000,2,1,0));
    tv.push_back(V(0,0,0,0,0,0,0,1, 1,3,0,0,0,0,0));
    tv.push_back(V(1,0,0,0,0,0,0,1, 1,0,0,0,0,0,0));
    // out of order
    tv.push_back(V(0,0,1,0,0,0,0,1, 1,1,0,0,0,1,0));
    tv.push_back(V(0,0,1,0,0,0,0,1, 1,2,0,0,0,1,0));
    tv.push_back(V(0,0,1,0,0,0,0,1, 1,3,0,0,0,1,0));
    tv.push_back(V(0,0,1,0,0,0,0,1, 0,0,0,0,0,1,0));
    tv.push_back(V(0,0,0,1,3,32'hA3A3A3A3,3,1, 0,0,0,0,0,1,0));
    tv.push_back(V(0,0,0,1,1,32'hA1A1A1A1,1,1, 0,0,0,0,0,1,0));
    tv.push_back(V(0,0,0,1,2,32'hA2A2A2A2,2,1, 0,0,0,0,0,1,0));
    tv.push_back(V(0,0,0,1,0,32'hA0A0A0A0,4,1,
                   0,0,1,32'hA0A0A0A0,4,1,0));
    tv.push_back(V(0,0,0,0,0,0,0,1, 1,0,1,32'hA1A1A1A1,1,1,0));
    tv.push_back(V(0,0,0,0,0,0,0,1, 1,0,1,32'hA2A2A2A2,2,1,0));
    tv.push_back(V(0,0,0,0,0,0,0,1, 1,0,1,32'hA3A3A3A3,3,1,0));
    tv.push_back(V(0,0,0,0,0,0,0,1, 1,0,0,0,0,0,0));
    // illegal writes
    tv.push_back(V(0,0,0,1,2,32'h0000DEAD,0,1, 1,0,0,0,0,0,1));
    tv.push_back(V(0,0,0,0,0,0,0,1, 1,0,0,0,0,0,0));
    tv.push_back(V(0,0,1,0,0,0,0,0, 1,1,0,0,0,1,0));
    tv.push_back(V(0,0,0,1,0,32'h11111111,5,0,
                   1,1,1,32'h11111111,5,1,0));
    tv.push_back(V(0,0,0,1,0,32'h22222222,31,0,
                   1,1,1,32'h11111111,5,1,1));
    tv.push_back(V(0,0,0,0,0,0,0,0, 1,1,1,32'h11111111,5,1,0));
    tv.push_back(V(0,0,0,0,0,0,0,1, 1,1,0,0,0,0,0));
    // flush
    tv.push_back(V(1,0,0,0,0,0,0,0, 1,0,0,0,0,0,0));
    tv.push_back(V(0,0,1,0,0,0,0,0, 1,1,0,0,0,1,0));
    tv.push_back(V(0,0,1,0,0,0,0,0, 1,2,0,0,0,1,0));
    tv.push_back(V(0,0,1,0,0,0,0,0, 1,3,0,0,0,1,0));
    tv.push_back(V(0,0,0,1,1,32'h55,0,0, 1,3,0,0,0,1,0));
    tv.push_back(V(0,1,0,1,2,32'h66,0,0, 1,0,0,0,0,0,0));
    tv.push_back(V(0,0,0,1,2,32'h77,0,0, 1,0,0,0,0,0,1));
    tv.push_back(V(0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0));
    // issue and result to the same slot in one cycle
    tv.push_back(V(0,0,1,1,0,32'h88,0,0, 1,1,0,0,0,1,1));
    tv.push_back(V(0,0,0,0,0,0,0,0, 1,1,0,0,0,1,0));
    tv.push_back(V(1,0,0,0,0,0,0,0, 1,0,0,0,0,0,0));

    drive(1, 0, 0, 0, 2'd0, 32'h0, 5'd0, 0);
    chk("rst_ir", 32'(ir), 32'd1);
    chk("rst_iid", 32'(iid), 32'd0);
    chk("rst_ov", 32'(ov), 32'd0);
    chk("rst_res", ores, 32'd0);
    chk("rst_st", 32'(ost), 32'd0);
    chk("rst_ext", 32'(oext), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("res_ready", 32'(rrdy), 32'd1);

    foreach (tv[k]) begin
      drive(tv[k].rst, tv[k].fl, tv[k].iv, tv[k].rv,
            tv[k].rid, tv[k].rres, tv[k].rs, tv[k].ordy);
      chk($sformatf("v%0d_ir", k), 32'(ir), 32'(tv[k].e_ir));
      chk($sformatf("v%0d_iid", k), 32'(iid), 32'(tv[k].e_iid));
      chk($sformatf("v%0d_ov", k), 32'(ov), 32'(tv[k].e_ov));
      chk($sformatf("v%0d_busy", k), 32'(busy),
          32'(tv[k].e_busy));
      chk($sformatf("v%0d_err", k), 32'(err), 32'(tv[k].e_err));
      if (tv[k].e_ov) begin
        chk($sformatf("v%0d_res", k), ores, tv[k].e_res);
        chk($sformatf("v%0d_st", k), 32'(ost), 32'(tv[k].e_st));
        chk($sformatf("v%0d_ext", k), 32'(oext),
            32'(tv[k].e_res[0]));
      end
    end

    // full, all done, held off for 5 cycles
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 2'd0, 32'h0, 5'd0, 0);
    end
    chk("full_ir", 32'(ir), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 2'(i), 32'hB0 + 32'(i), 5'(i), 0);
    end
    for (int i = 0; i < 5; i++) begin
      idle(0);
      chk($sformatf("bp%0d_ov", i), 32'(ov), 32'd1);
      chk($sformatf("bp%0d_res", i), ores, 32'hB0);
      chk($sformatf("bp%0d_st", i), 32'(ost), 32'd0);
      chk($sformatf("bp%0d_ir", i), 32'(ir), 32'd0);
    end
    idle(1);
    chk("bp_ir_rise", 32'(ir), 32'd1);
    chk("bp_next_res", ores, 32'hB1);
    for (int i = 2; i < 5; i++) begin
      idle(1);
      chk($sformatf("drain%0d_ov", i), 32'(ov),
          32'(i < 4));
      if (i < 4) chk($sformatf("drain%0d_res", i), ores,
                     32'hB0 + 32'(i));
    end
    chk("drain_busy", 32'(busy), 32'd0);

    // wrap-around
    drive(1, 0, 0, 0, 2'd0, 32'h0, 5'd0, 1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("wrap%0d_iid", i), 32'(iid), 32'(i % 4));
      drive(0, 0, 1, 0, 2'd0, 32'h0, 5'd0, 1);
      drive(0, 0, 0, 1, 2'(i % 4), 32'hC00 + 32'(i),
            5'(i), 1);
      chk($sformatf("wrap%0d_ov", i), 32'(ov), 32'd1);
      chk($sformatf("wrap%0d_res", i), ores, 32'hC00 + 32'(i));
      chk($sformatf("wrap%0d_st", i), 32'(ost), 32'(i));
      idle(1);
      chk($sformatf("wrap%0d_done", i), 32'(ov), 32'd0);
      chk($sformatf("wrap%0d_err", i), 32'(err), 32'd0);
    end
    chk("wrap_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpnew_result_reorder.md
# fpnew_result_reorder

In-order completion buffer on the consumer side of an FP opgroup block's result interface. Formats inside an opgroup run at different latencies and are merged by a round-robin arbiter, so results can leave out of issue order. This block allocates a slot ID at issue time; the ID travels through the FPU as the operation tag. Returned results are written into their slots and released strictly in issue order.

## Interface
- Width, 32: result width in bits.
- Depth, 4: number of slots/outstanding ops; power of two, ≥2. Localparam IdWidth = $clog2(Depth).
- clk_i  in  1  clock.
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- flush_i  in  1  discard all outstanding ops.
- issue_valid_i  in  1  request to allocate a slot.
- issue_ready_o  out  1  slot available.
- issue_id_o  out  IdWidth  ID of the slot allocated on handshake; used as the FPU tag.
- res_valid_i  in  1  result from opgroup block.
- res_ready_o  out  1  result accepted; constant 1.
- res_id_i  in  IdWidth  returned tag.
- res_result_i  in  Width  result data.
- res_status_i  in  5  fpnew_pkg::status_t {NV,DZ,OF,UF,NX}.
- res_ext_bit_i  in  1  extension bit.
- out_valid_o  out  1  head result ready to commit.
- out_ready_i  in  1  consumer accepts.
- out_result_o / out_status_o / out_ext_bit_o  out  Width/5/1  committed payload.
- busy_o  out  1  at least one slot allocated.
- error_o  out  1  one-cycle pulse on an illegal result write.

## Operation
- State: per-slot alloc and done bits plus a payload register; head (commit) and tail (alloc) pointers of IdWidth bits; count of IdWidth+1 bits.
- Issue: issue_ready_o = (count < Depth); issue_id_o = tail. On handshake: alloc[tail]=1, done[tail]=0, tail++ mod Depth.
- Result write: if alloc[res_id_i] && !done[res_id_i], store the payload and set done. Otherwise drop the payload and pulse error_o the next cycle.
- Commit: out_valid_o = done[head]; outputs are driven from slot[head] registers. On out_valid_o && out_ready_i: clear alloc[head] and done[head], head++ mod Depth.
- count: +1 on issue, -1 on commit, unchanged when both occur in the same cycle.
- busy_o = (count != 0).
- flush_i, or rst_i, has priority over everything in that cycle:
  - clears all alloc and done bits;
  - sets head = tail = count = 0;
  - same-cycle issue, result and commit have no effect;
  - no error_o pulse for a result dropped by flush.
- Results arriving for pre-flush IDs after the flush are illegal writes and pulse error_o.

## Timing
- Reset values:
  - issue_ready_o=1, issue_id_o=0
  - out_valid_o=0, out_result_o=0, out_status_o=0, out_ext_bit_o=0
  - busy_o=0, error_o=0
- Latency from result write to commit: a result written in cycle N for the head slot gives out_valid_o=1 in cycle N+1.
- Sustained throughput is one commit per cycle.
- There is no combinational path from any res_* input or from out_ready_i to any output; all outputs derive from registers.
- issue_ready_o depends only on count. When the buffer is full and a commit happens in cycle N, issue_ready_o rises in N+1. Same-cycle reuse of a freed slot is not supported.
- Same-cycle issue to slot k and result for ID k: the slot is not yet allocated, so the result is an illegal write (error_o).
- While out_ready_i=0, out_valid_o and all out payload signals stay stable.
- Pointer wrap: Depth-1 → 0. When full, head == tail and count == Depth.

## Test plan
- In order, Depth=4:
  - Stimulus: issue 3 ops (IDs 0,1,2); return ID0=0x3F800000, ID1=0x40000000, ID2=0x40400000 on consecutive cycles; out_ready_i=1.
  - Required: three commits in the same order, each one cycle after its write; busy_o falls after the last commit.
- Out of order:
  - Stimulus: issue 4 ops; return IDs in order 3,1,2,0.
  - Required: issue_ready_o=0 after the 4th issue; out_valid_o stays 0 until ID0 is written; then 4 consecutive commits, IDs 0,1,2,3, with matching payload and status.
- Backpressure and full:
  - Stimulus: buffer full and all done, out_ready_i=0 for 5 cycles, then 1.
  - Required: out payload stable for those 5 cycles; issue_ready_o rises the cycle after the first commit.
- Wrap-around:
  - Stimulus: 10 issue/result/commit sequences.
  - Required: issue_id_o sequence 0,1,2,3,0,1,2,3,0,1; all commits in order with no error_o.
- Errors:
  - Stimulus: a result for an unallocated ID; a second result for an already-done ID.
  - Required: error_o pulses once for each; stored data unchanged.
- Flush:
  - Stimulus: 3 ops outstanding, ID1 done; assert flush_i together with a res_valid_i.
  - Required: the next cycle shows busy_o=0, out_valid_o=0, issue_id_o=0 and no error_o; a later result for old ID2 pulses error_o.
